btn_debounce: RTL and testbench

- Cleans one raw mechanical push-button input and produces a debounced level `q` plus single-cycle event ticks.
- Sits directly upstream of the score counters and seven-segment display path, and of the sound trigger.
- Its `db_clk` tick is the only increment source for a score digit pair.
- Optional hold-to-repeat lets a held button advance a counter at a steady rate.

---
 rtl/btn_pkg.sv | 18 +
 rtl/sync_2ff.sv | 29 ++
 rtl/btn_debounce.sv | 139 +++++++++++++
 tb/tb_btn_debounce.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and 25 MHz timing defaults for the push-button debouncer.
package btn_pkg;

    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        WAIT1 = 3'd1,
        ONE   = 3'd2,
        HOLD  = 3'd3,
        WAIT0 = 3'd4
    } state_t;

    // 20 ms, 0.5 s and 0.1 s at 25 MHz
    localparam int DEF_STABLE_CYCLES = 500000;
    localparam int DEF_HOLD_CYCLES   = 12500000;
    localparam int DEF_REPEAT_CYCLES = 2500000;
    localparam int DEF_CNT_W         = 24;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous level input; clears to 0 on reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/btn_debounce.sv
// Debounces one raw button into a registered level plus one-cycle press,
// repeat and release ticks, using a single shared timing counter.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter bit REPEAT_EN     = 1'b0,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic q,
    output logic db_clk,
    output logic db_rel
);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic s;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_q, q_d;
    logic             db_clk_q, db_clk_d;
    logic             db_rel_q, db_rel_d;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (reset),
        .d     (raw),
        .q     (s)
    );

    // Every terminal count clears the counter, so it never needs to wrap.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        db_clk_d = 1'b0;
        db_rel_d = 1'b0;
        q_d      = 1'b0;

        case (state_q)
            ZERO: begin
                cnt_d = '0;
                if (s) begin
                    state_d = WAIT1;
                end
            end
            WAIT1: begin
                if (!s) begin
                    state_d = ZERO;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d  = ONE;
                    db_clk_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ONE: begin
                if (!s) begin
                    state_d = WAIT0;
                    cnt_d   = '0;
                end else if (REPEAT_EN) begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d  = HOLD;
                        db_clk_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            HOLD: begin
                if (!s) begin
                    state_d = WAIT0;
                    cnt_d   = '0;
                end else if (cnt_q == REPEAT_LAST) begin
                    db_clk_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT0: begin
                if (s) begin
                    // Bounce back to pressed restarts the hold timer silently.
                    state_d = ONE;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d  = ZERO;
                    db_rel_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ZERO;
                cnt_d   = '0;
            end
        endcase

        case (state_d)
            ONE, HOLD, WAIT0: q_d = 1'b1;
            default:          q_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ZERO;
            cnt_q    <= '0;
            q_q      <= 1'b0;
            db_clk_q <= 1'b0;
            db_rel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            q_q      <= q_d;
            db_clk_q <= db_clk_d;
            db_rel_q <= db_rel_d;
        end
    end

    assign q      = q_q;
    assign db_clk = db_clk_q;
    assign db_rel = db_rel_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench: one single-shot debouncer and one with hold-to-repeat,
// each fed its own raw input; expected ticks are queued with their cycle.
module tb_btn_debounce;

    typedef struct {
        bit is_rel;
        int cyc;
    } exp_t;

    logic clk;
    logic reset;
    logic raw0, raw1;
    logic q0, db_clk0, db_rel0;
    logic q1, db_clk1, db_rel1;

    int cycle    = 0;
    int checks   = 0;
    int passes   = 0;
    int tick_cnt0 = 0;
    int tick_cnt1 = 0;
    exp_t sb0[$];
    exp_t sb1[$];

    btn_debounce #(
        .STABLE_CYCLES (4),
        .HOLD_CYCLES   (10),
        .REPEAT_CYCLES (3),
        .REPEAT_EN     (1'b0),
        .CNT_W         (8)
    ) dut0 (
        .clk    (clk),
        .reset  (reset),
        .raw    (raw0),
        .q      (q0),
        .db_clk (db_clk0),
        .db_rel (db_rel0)
    );

    btn_debounce #(
        .STABLE_CYCLES (4),
        .HOLD_CYCLES   (10),
        .REPEAT_CYCLES (3),
        .REPEAT_EN     (1'b1),
        .CNT_W         (8)
    ) dut1 (
        .clk    (clk),
        .reset  (reset),
        .raw    (raw1),
        .q      (q1),
        .db_clk (db_clk1),
        .db_rel (db_rel1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input int which, input logic val);
        if (which == 0) raw0 = val;
        else            raw1 = val;
    endtask

    // Queue a tick expected `offset` sampled cycles after the current negedge.
    task automatic expectTick(input int which, input bit is_rel, input int offset);
        exp_t e;
        e.is_rel = is_rel;
        e.cyc    = cycle + offset;
        if (which == 0) sb0.push_back(e);
        else            sb1.push_back(e);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic popAndCompare(input string name, inout exp_t sb[$], input bit is_rel);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            $display("[TB] FAIL %s: unexpected %s tick at cycle %0d, none expected",
                     name, is_rel ? "rel" : "clk", cycle);
        end else begin
            e = sb.pop_front();
            if (e.is_rel == is_rel && e.cyc == cycle) passes++;
            else $display("[TB] FAIL %s: got %s tick at cycle %0d, expected %s tick at cycle %0d",
                          name, is_rel ? "rel" : "clk", cycle,
                          e.is_rel ? "rel" : "clk", e.cyc);
        end
    endtask

    // Monitor: every tick the DUTs present is matched against the queues.
    always @(negedge clk) begin
        if (db_clk0 && db_rel0) begin
            checks++;
            $display("[TB] FAIL dut0_exclusive: db_clk=1 db_rel=1 at cycle %0d, required not both", cycle);
        end else if (db_clk0 || db_rel0) begin
            popAndCompare("dut0_tick", sb0, db_rel0);
        end
        if (db_clk1 && db_rel1) begin
            checks++;
            $display("[TB] FAIL dut1_exclusive: db_clk=1 db_rel=1 at cycle %0d, required not both", cycle);
        end else if (db_clk1 || db_rel1) begin
            popAndCompare("dut1_tick", sb1, db_rel1);
        end
        if (db_clk0) tick_cnt0++;
        if (db_clk1) tick_cnt1++;
    end

    initial begin
        int t;
        reset = 1'b0;
        raw0  = 1'b1;
        raw1  = 1'b0;

        // Reset held with the button pressed.
        waitCycles(5);
        checkOutput("reset_q0", int'(q0), 0);
        checkOutput("reset_db_clk0", int'(db_clk0), 0);
        checkOutput("reset_db_rel0", int'(db_rel0), 0);
        checkOutput("reset_q1", int'(q1), 0);

        // Still pressed after reset: treated as a fresh press.
        reset = 1'b1;
        expectTick(0, 1'b0, 7);
        waitCycles(12);
        checkOutput("press_after_reset_q", int'(q0), 1);

        // Three-cycle low glitch while pressed: no release.
        applyStimulus(0, 1'b0);
        waitCycles(3);
        applyStimulus(0, 1'b1);
        waitCycles(12);
        checkOutput("glitch_low_q", int'(q0), 1);

        // Release with edge-exact level checks.
        applyStimulus(0, 1'b0);
        expectTick(0, 1'b1, 7);
        waitCycles(6);
        checkOutput("release_q_before", int'(q0), 1);
        waitCycles(1);
        checkOutput("release_q_after", int'(q0), 0);
        waitCycles(10);

        // Clean press held 20 cycles, single-shot.
        t = tick_cnt0;
        applyStimulus(0, 1'b1);
        expectTick(0, 1'b0, 7);
        waitCycles(6);
        checkOutput("press_q_before", int'(q0), 0);
        waitCycles(1);
        checkOutput("press_q_after", int'(q0), 1);
        waitCycles(13);
        checkOutput("press_q_held", int'(q0), 1);
        checkOutput("press_tick_count", tick_cnt0 - t, 1);

        applyStimulus(0, 1'b0);
        expectTick(0, 1'b1, 7);
        waitCycles(12);
        checkOutput("release2_q", int'(q0), 0);

        // Bouncing press: two 2-cycle highs, then settles high.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 1'b1);
            waitCycles(2);
            applyStimulus(0, 1'b0);
            waitCycles(2);
        end
        applyStimulus(0, 1'b1);
        expectTick(0, 1'b0, 7);
        waitCycles(6);
        checkOutput("bounce_q_before", int'(q0), 0);
        waitCycles(6);
        checkOutput("bounce_q_after", int'(q0), 1);
        applyStimulus(0, 1'b0);
        expectTick(0, 1'b1, 7);
        waitCycles(12);

        // Hold-to-repeat: press tick, +10, then every 3 cycles for 40 cycles.
        t = tick_cnt1;
        applyStimulus(1, 1'b1);
        expectTick(1, 1'b0, 7);
        expectTick(1, 1'b0, 17);
        for (int k = 0; k < 8; k++) expectTick(1, 1'b0, 20 + 3 * k);
        waitCycles(40);
        applyStimulus(1, 1'b0);
        expectTick(1, 1'b1, 7);
        waitCycles(12);
        checkOutput("repeat_tick_count", tick_cnt1 - t, 10);
        checkOutput("repeat_q_released", int'(q1), 0);

        // Reset part-way through the stability count discards progress.
        applyStimulus(0, 1'b1);
        waitCycles(4);
        reset = 1'b0;
        waitCycles(1);
        checkOutput("midreset_q", int'(q0), 0);
        reset = 1'b1;
        expectTick(0, 1'b0, 7);
        waitCycles(6);
        checkOutput("midreset_q_before", int'(q0), 0);
        waitCycles(6);
        checkOutput("midreset_q_after", int'(q0), 1);

        waitCycles(5);
        checkOutput("sb0_drained", sb0.size(), 0);
        checkOutput("sb1_drained", sb1.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
